audio_decimator: RTL and testbench

AUDIO_DECIMATOR -- requirements
Module: audio_decimator

---
 rtl/audio_pkg.sv | 8 +
 rtl/audio_decimator.sv | 63 ++++++
 tb/tb_audio_decimator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults, FSM state encoding and legal RATE_LOG2 range for the audio decimator
package audio_pkg;
    localparam int WORD_BYTES_DEF = 2;
    localparam int RATE_LOG2_MIN = 1;
    localparam int RATE_LOG2_MAX = 8;
    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_LAST = 1'b1;
endpackage

// File: rtl/audio_decimator.sv
// audio_decimator: block-average decimator by 2**RATE_LOG2; define AUDIO_DECIMATOR_ROUND_EN for round-half-up
module audio_decimator
    import audio_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int RATE_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    s_tvalid,
    input  logic [8*WORD_BYTES-1:0] s_tdata,
    output logic                    s_tready,
    output logic                    m_tvalid,
    output logic [8*WORD_BYTES-1:0] m_tdata,
    input  logic                    m_tready
);
    localparam int W = 8 * WORD_BYTES;
    localparam int AW = W + RATE_LOG2;
`ifdef AUDIO_DECIMATOR_ROUND_EN
    localparam logic [AW-1:0] HALF = AW'(1) << (RATE_LOG2 - 1);
`endif
    logic [RATE_LOG2-1:0] cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d, sum, rnd;
    logic                 m_tvalid_q, m_tvalid_d;
    logic [W-1:0]         m_tdata_q, m_tdata_d;
    logic                 state, accept, load;

    // Handshake, accumulation and output-register next state; state is implied by the count
    always_comb begin
        state = (&cnt_q) ? ST_LAST : ST_ACCUM;
        s_tready = reset_n & ((state == ST_ACCUM) | ~m_tvalid_q | m_tready);
        accept = s_tvalid & s_tready;
        load = accept & (state == ST_LAST);
        sum = acc_q + {{RATE_LOG2{s_tdata[W-1]}}, s_tdata};
`ifdef AUDIO_DECIMATOR_ROUND_EN
        rnd = sum + HALF;
`else
        rnd = sum;
`endif
        acc_d = accept ? (load ? '0 : sum) : acc_q;
        cnt_d = accept ? (load ? '0 : cnt_q + 1'b1) : cnt_q;
        m_tvalid_d = load | (m_tvalid_q & ~m_tready);
        m_tdata_d = load ? W'(rnd >>> RATE_LOG2) : m_tdata_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q <= m_tdata_d;
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tdata = m_tdata_q;
endmodule

// File: tb/tb_audio_decimator.sv
// tb_audio_decimator: directed and random checks of audio_decimator (WORD_BYTES=2, RATE_LOG2=2) against a sample-queue model
module tb_audio_decimator;
    localparam int N = 4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        s_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tready = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int          out_cnt = 0;
    bit          chk_en = 1'b0;
    int          q[$];
    bit          ev = 1'b0;
    logic [15:0] ed = '0;

    audio_decimator #(.WORD_BYTES(2), .RATE_LOG2(2)) dut (
        .clk(clk), .reset_n(reset_n), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] avg(int s);
        int t = s;
`ifdef AUDIO_DECIMATOR_ROUND_EN
        t = t + N / 2;
`endif
        return 16'(t >>> 2);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: gather accepted samples, emit the average of every group of N
    always @(posedge clk) begin
        bit acc;
        int s;
        if (!reset_n) begin
            q.delete();
            ev = 1'b0;
            ed = '0;
        end else begin
            acc = s_tvalid && (q.size() < N - 1 || !ev || m_tready);
            if (ev && m_tready) ev = 1'b0;
            if (acc) begin
                q.push_back(int'($signed(s_tdata)));
                if (q.size() == N) begin
                    s = 0;
                    foreach (q[i]) s += q[i];
                    ed = avg(s);
                    ev = 1'b1;
                    q.delete();
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_tready", 32'(s_tready), 32'(reset_n && (q.size() < N - 1 || !ev || m_tready)));
            chk("m_tvalid", 32'(m_tvalid), 32'(ev));
            chk("m_tdata", 32'(m_tdata), 32'(ed));
            if (reset_n && m_tvalid && m_tready) out_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [15:0] d, logic r);
        s_tvalid = v;
        s_tdata = d;
        m_tready = r;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b1);
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        reset_n = 1'b1;
    endtask

    task automatic send4(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
        drive(1'b1, a, 1'b1); cyc();
        drive(1'b1, b, 1'b1); cyc();
        drive(1'b1, c, 1'b1); cyc();
        drive(1'b1, d, 1'b1); cyc();
    endtask

    initial begin
        int o0;
        int low;
        do_reset();
        drive(1'b1, 16'h7fff, 1'b1);
        repeat (3) cyc();
        chk("r27_pre_valid", 32'(m_tvalid), 0);
        cyc();
        chk("r27_valid", 32'(m_tvalid), 1);
        chk("r27_data", 32'(m_tdata), 32'h7fff);
        drive(1'b0, '0, 1'b1);
        cyc();
        chk("r27_consumed", 32'(m_tvalid), 0);
        send4(16'h0001, 16'h0001, 16'h0000, 16'h0000);
`ifdef AUDIO_DECIMATOR_ROUND_EN
        chk("r28_small", 32'(m_tdata), 32'h0001);
`else
        chk("r28_small", 32'(m_tdata), 32'h0000);
`endif
        send4(16'hffff, 16'hffff, 16'hffff, 16'hffff);
        chk("r28_neg1", 32'(m_tdata), 32'hffff);
        send4(16'h7fff, 16'h8000, 16'h7fff, 16'h8000);
`ifdef AUDIO_DECIMATOR_ROUND_EN
        chk("r29_alt", 32'(m_tdata), 32'h0000);
`else
        chk("r29_alt", 32'(m_tdata), 32'hffff);
`endif
        chk("r29_valid", 32'(m_tvalid), 1);
        do_reset();
        drive(1'b1, 16'h0010, 1'b0);
        repeat (7) cyc();
        chk("r30_stall", 32'(s_tready), 0);
        chk("r30_first_valid", 32'(m_tvalid), 1);
        chk("r30_first_data", 32'(m_tdata), 32'h0010);
        repeat (2) cyc();
        chk("r30_hold_data", 32'(m_tdata), 32'h0010);
        chk("r30_hold_stall", 32'(s_tready), 0);
        m_tready = 1'b1;
        #1;
        chk("r30_release", 32'(s_tready), 1);
        cyc();
        chk("r30_load_wins", 32'(m_tvalid), 1);
        chk("r30_second_data", 32'(m_tdata), 32'h0010);
        drive(1'b0, '0, 1'b0);
        cyc();
        chk("r30_second_held", 32'(m_tvalid), 1);
        m_tready = 1'b1;
        cyc();
        chk("r30_drained", 32'(m_tvalid), 0);
        do_reset();
        drive(1'b1, 16'h4000, 1'b1);
        repeat (2) cyc();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b1);
        cyc();
        reset_n = 1'b1;
        o0 = out_cnt;
        drive(1'b1, 16'h0100, 1'b1);
        repeat (3) cyc();
        chk("r31_no_early", 32'(m_tvalid), 0);
        cyc();
        chk("r31_data", 32'(m_tdata), 32'h0100);
        drive(1'b0, '0, 1'b1);
        repeat (4) cyc();
        chk("r31_count", 32'(out_cnt - o0), 1);
        do_reset();
        o0 = out_cnt;
        low = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'($urandom), 1'b1);
            #1;
            if (!s_tready) low++;
            cyc();
        end
        drive(1'b0, '0, 1'b1);
        cyc();
        chk("r32_ready_low", 32'(low), 0);
        chk("r32_outputs", 32'(out_cnt - o0), 4);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
